fxp_result_fifo: RTL and testbench
==================================

// Module: fxp_result_fifo
// PURPOSE
//  Downstream stage of the 16-bit Q-format saturating adder datapath. Captures
//  each result presented with its one-cycle valid pulse into a DEPTH-entry
//  first-word-fall-through FIFO. A consumer drains it with a valid/ready
//  handshake. Also keeps a saturating count of clipped results (0x7FFF/0x8000)
//  and a sticky overflow flag for results dropped while full.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  SAT_W   8   width of saturation-event counter
// PORTS
//  CLK          in   1              rising-edge clock
//  RST          in   1              reset: synchronous, active-low
//  res_in       in   16 signed      result word from adder (c_out)
//  res_valid_in in   1              result valid pulse (c_valid_out)
//  clr_in       in   1              synchronous clear of FIFO, flags, counter
//  out_data     out  16 signed      head-of-FIFO word
//  out_valid    out  1              head word valid (FIFO not empty)
//  out_ready    in   1              consumer accepts head word
//  count_out    out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  full_out     out  1              count_out == DEPTH
//  empty_out    out  1              count_out == 0
//  ovf_out      out  1              sticky: a result was dropped
//  sat_cnt_out  out  SAT_W          number of results equal to 0x7FFF/0x8000
// BEHAVIOUR
//  - Reset (RST==0 at CLK edge): rd/wr ptrs=0, count_out=0, out_valid=0,
//    empty_out=1, full_out=0, ovf_out=0, sat_cnt_out=0. Storage not cleared;
//    out_data undefined-but-stable while empty. Reset mid-traffic discards all.
//  - clr_in==1 (RST==1): identical effect to reset; same-cycle push/pop ignored.
//  - Priority: RST > clr_in > push/pop.
//  - pop = out_valid & out_ready. push = res_valid_in & (!full_out | pop).
//  - Push writes res_in at wr_ptr, wr_ptr++ (mod DEPTH). Pop: rd_ptr++.
//  - count_out: +1 push only, -1 pop only, unchanged push&pop or neither.
//  - Simultaneous push+pop when full: both occur, count stays DEPTH, no ovf.
//  - Simultaneous push+pop when empty: impossible (out_valid=0), push only.
//  - res_valid_in & full_out & !pop: word dropped, ovf_out<=1 (sticky until
//    RST/clr_in); storage, ptrs, count unchanged.
//  - FWFT: out_data = mem[rd_ptr], out_valid = !empty_out; word pushed into an
//    empty FIFO appears on out_data/out_valid the cycle after the push edge
//    (latency 1). out_data holds while out_valid & !out_ready.
//  - Pointers wrap DEPTH-1 -> 0; full/empty from count_out, not pointers.
//  - sat_cnt_out: +1 on every res_valid_in cycle with res_in==16'h7FFF or
//    16'h8000, whether pushed or dropped; saturates at 2^SAT_W-1, no wrap.
//  - All outputs registered or decoded from registers only; no combinational
//    path from res_in/res_valid_in to any output. out_valid does not depend
//    on out_ready.
// TESTING
//  1 Reset: RST=0 two cycles with res_valid_in=1 -> count 0, empty 1, ovf 0,
//    sat_cnt 0; after release out_valid stays 0.
//  2 Push 0x0010,0x7FFF,0x8000 (out_ready=0) -> count 3, out_data=0x0010,
//    sat_cnt 2; then out_ready=1 -> 0x0010,0x7FFF,0x8000 in order, empty.
//  3 Fill 8 words, push 9th with out_ready=0 -> full 1, ovf 1, count 8, 9th
//    word never emitted; ovf stays 1 until clr_in pulse.
//  4 Full FIFO, push 0x1234 with out_ready=1 same cycle -> count stays 8,
//    ovf 0, 0x1234 emerges 8th after the popped word.
//  5 Stream 20 words with out_ready toggling 1/0 -> pointer wrap, output
//    order matches input, count never exceeds 8.
//  6 clr_in=1 with push+pop active and count=5 -> next cycle count 0, empty,
//    ovf 0, sat_cnt 0; 300 saturated pushes with SAT_W=8 -> sat_cnt 255.

Source files
------------

// File: rtl/fxp_result_fifo.sv
// ============================================================================
// Module   : fxp_result_fifo
// Purpose  : FWFT result FIFO with saturation-event counter and sticky overflow
// Revision : 1.0
// ============================================================================
`default_nettype none

module fxp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int SAT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic signed [15:0]         res_in,
    input  logic                       res_valid_in,
    input  logic                       clr_in,
    output logic signed [15:0]         out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       ovf_out,
    output logic [SAT_W-1:0]           sat_cnt_out
);

    localparam int                   c_PTR_W   = $clog2(DEPTH);
    localparam int                   c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [SAT_W-1:0]     c_SAT_ONE = SAT_W'(1);
    localparam logic [SAT_W-1:0]     c_SAT_MAX = '1;
    localparam logic [15:0]          c_POS_SAT = 16'h7FFF;
    localparam logic [15:0]          c_NEG_SAT = 16'h8000;

    logic signed [15:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_ovf;
    logic [SAT_W-1:0]       r_sat_cnt;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_is_sat;
    logic                   w_clear;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_pop    = !w_empty && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push   = res_valid_in && (!w_full || w_pop);
    assign w_drop   = res_valid_in && w_full && !w_pop;
    assign w_is_sat = (res_in == c_POS_SAT) || (res_in == c_NEG_SAT);
    assign w_clear  = !RST || clr_in;

    // Storage is deliberately left out of reset; only the pointers define content.
    always_ff @(posedge CLK) begin
        if (!w_clear && w_push) begin
            r_mem[r_wr_ptr] <= res_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_clear) begin
            r_ovf     <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            // Counted on every valid result, whether stored or dropped.
            if (res_valid_in && w_is_sat && (r_sat_cnt != c_SAT_MAX)) begin
                r_sat_cnt <= r_sat_cnt + c_SAT_ONE;
            end
        end
    end

    assign out_data    = r_mem[r_rd_ptr];
    assign out_valid   = !w_empty;
    assign count_out   = r_count;
    assign full_out    = w_full;
    assign empty_out   = w_empty;
    assign ovf_out     = r_ovf;
    assign sat_cnt_out = r_sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fxp_result_fifo.sv
// ============================================================================
// Module   : tb_fxp_result_fifo
// Purpose  : Self-checking bench for fxp_result_fifo against a queue model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fxp_result_fifo;

    localparam int DEPTH = 8;
    localparam int SAT_W = 8;

    logic                CLK;
    logic                RST;
    logic signed [15:0]  res_in;
    logic                res_valid_in;
    logic                clr_in;
    logic signed [15:0]  out_data;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          count_out;
    logic                full_out;
    logic                empty_out;
    logic                ovf_out;
    logic [SAT_W-1:0]    sat_cnt_out;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq[$];
    logic        m_ovf;
    int          m_sat;

    fxp_result_fifo #(.DEPTH(DEPTH), .SAT_W(SAT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .res_in       (res_in),
        .res_valid_in (res_valid_in),
        .clr_in       (clr_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count_out    (count_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .ovf_out      (ovf_out),
        .sat_cnt_out  (sat_cnt_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one cycle of inputs, advance the reference model, sample 1 unit after the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic rdy,
                         input logic clr, input logic rstn);
        bit pop;
        res_valid_in = v;
        res_in       = d;
        out_ready    = rdy;
        clr_in       = clr;
        RST          = rstn;
        @(posedge CLK);
        if (!rstn || clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_sat = 0;
        end else begin
            pop = (mq.size() > 0) && rdy;
            if (v && (d == 16'h7FFF || d == 16'h8000) && m_sat < 255) m_sat++;
            if (pop) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 16'($urandom_range(1, 16'h7FFE)), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        cycle(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        total++; if (count_out !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        total++; if (empty_out !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty_out); end
        total++; if (full_out !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full_out); end
        total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_out); end
        total++; if (sat_cnt_out !== 8'd0) begin bad++; $display("FAIL reset_sat got=%0d exp=0", sat_cnt_out); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_idle got=%b exp=0", out_valid); end
        end
        fill(3);
        cycle(1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        total++; if (count_out !== 4'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_midtraffic count=%0d valid=%b exp=0/0", count_out, out_valid); end
    endtask

    task automatic test_order();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0010; exp_w[1] = 16'h7FFF; exp_w[2] = 16'h8000;
        cycle(1'b1, exp_w[0], 1'b0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 16'h0010) begin
            bad++; $display("FAIL fwft_latency valid=%b data=%h exp=1/0010", out_valid, out_data); end
        cycle(1'b1, exp_w[1], 1'b0, 1'b0, 1'b1);
        cycle(1'b1, exp_w[2], 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        total++; if (count_out !== 4'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count_out); end
        total++; if (out_data !== 16'h0010) begin bad++; $display("FAIL order_hold got=%h exp=0010", out_data); end
        total++; if (sat_cnt_out !== 8'd2) begin bad++; $display("FAIL order_sat got=%0d exp=2", sat_cnt_out); end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                bad++; $display("FAIL order_word%0d got=%h exp=%h", i, out_data, exp_w[i]); end
            cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        end
        total++; if (empty_out !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL order_empty empty=%b valid=%b exp=1/0", empty_out, out_valid); end
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        fill(8);
        total++; if (full_out !== 1'b1 || count_out !== 4'd8) begin
            bad++; $display("FAIL full_flag full=%b count=%0d exp=1/8", full_out, count_out); end
        total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf_out); end
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        total++; if (ovf_out !== 1'b1 || count_out !== 4'd8) begin
            bad++; $display("FAIL ovf_drop ovf=%b count=%0d exp=1/8", ovf_out, count_out); end
        while (mq.size() > 0) begin
            w = mq[0];
            total++; if (out_valid !== 1'b1 || out_data !== w) begin
                bad++; $display("FAIL ovf_drain got=%h exp=%h", out_data, w); end
            cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        end
        total++; if (out_valid !== 1'b0 || ovf_out !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky valid=%b ovf=%b exp=0/1", out_valid, ovf_out); end
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf_out); end
    endtask

    task automatic test_full_pushpop();
        logic [15:0] w;
        fill(8);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        total++; if (count_out !== 4'd8 || ovf_out !== 1'b0) begin
            bad++; $display("FAIL full_pushpop count=%0d ovf=%b exp=8/0", count_out, ovf_out); end
        for (int i = 0; i < 8; i++) begin
            w = mq[0];
            total++; if (out_data !== w) begin bad++; $display("FAIL full_pushpop_word%0d got=%h exp=%h", i, out_data, w); end
            cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        end
        total++; if (w !== 16'h1234) begin bad++; $display("FAIL full_pushpop_last got=%h exp=1234", w); end
    endtask

    task automatic test_stream(input int n, input bit random_mode);
        logic v, rdy;
        logic [15:0] d;
        int sent = 0;
        int cyc = 0;
        while ((random_mode ? cyc < n : sent < n) && cyc < 5000) begin
            if (random_mode) begin
                v   = 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
                case ($urandom_range(0, 5))
                    0: d = 16'h7FFF;
                    1: d = 16'h8000;
                    default: d = 16'($urandom());
                endcase
            end else begin
                v = 1'b1; rdy = cyc[0]; d = 16'($urandom());
            end
            cycle(v, d, rdy, 1'b0, 1'b1);
            if (v) sent++;
            cyc++;
            total++; if (count_out !== 4'(mq.size()) || out_valid !== (mq.size() > 0)
                         || full_out !== (mq.size() == DEPTH) || empty_out !== (mq.size() == 0)) begin
                bad++; $display("FAIL stream_state cyc=%0d count=%0d valid=%b exp_count=%0d", cyc, count_out, out_valid, mq.size()); end
            if (mq.size() > 0) begin
                total++; if (out_data !== mq[0]) begin
                    bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]); end
            end
            total++; if (ovf_out !== m_ovf || sat_cnt_out !== 8'(m_sat)) begin
                bad++; $display("FAIL stream_flags cyc=%0d ovf=%b sat=%0d exp=%b/%0d", cyc, ovf_out, sat_cnt_out, m_ovf, m_sat); end
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        total++; if (empty_out !== 1'b1) begin bad++; $display("FAIL stream_drain empty=%b exp=1", empty_out); end
    endtask

    task automatic test_clear_sat();
        fill(5);
        cycle(1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        total++; if (count_out !== 4'd0 || empty_out !== 1'b1 || ovf_out !== 1'b0 || sat_cnt_out !== 8'd0) begin
            bad++; $display("FAIL clr count=%0d empty=%b ovf=%b sat=%0d exp=0/1/0/0", count_out, empty_out, ovf_out, sat_cnt_out); end
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, i[0] ? 16'h8000 : 16'h7FFF, 1'b1, 1'b0, 1'b1);
            if (i == 253) begin
                total++; if (sat_cnt_out !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", sat_cnt_out); end
            end
        end
        total++; if (sat_cnt_out !== 8'd255) begin bad++; $display("FAIL sat_cap got=%0d exp=255", sat_cnt_out); end
        total++; if (ovf_out !== 1'b0) begin bad++; $display("FAIL sat_no_ovf got=%b exp=0", ovf_out); end
    endtask

    initial begin
        RST = 1'b0; clr_in = 1'b0; res_valid_in = 1'b0; res_in = '0; out_ready = 1'b0;
        m_ovf = 1'b0; m_sat = 0;
        test_reset();
        test_order();
        test_overflow();
        test_full_pushpop();
        test_stream(20, 1'b0);
        test_stream(400, 1'b1);
        test_clear_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
